alarm_ringer: RTL

- Consumer end of the alarm trigger interface. Takes the level-style `alarm` match signal and the user stop/snooze button pulses.
- Produces a gated, pulsed buzzer drive plus ringing and snooze status for the display/LED logic.
- Sits between the alarm comparator and the board buzzer/LED pins.
- Owns all annunciation timing: ring timeout, snooze countdown and beep cadence.

---
 rtl/alarm_ringer.sv | 84 ++++++++
 1 files changed

// File: rtl/alarm_ringer.sv
// alarm_ringer: turns an alarm match level plus stop/snooze buttons into a pulsed buzzer with ring timeout and snooze countdown
module alarm_ringer #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MINS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alarm,
  input  logic        enable,
  input  logic        stop_btn,
  input  logic        snooze_btn,
  output logic        buzzer,
  output logic        ringing,
  output logic        snoozed,
  output logic [11:0] snooze_left
);
  localparam int PW = $clog2(CLK_FREQ);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  state_t state;
  logic alarm_q;
  logic [PW-1:0] prescaler;
  logic [11:0] sec_cnt;
  logic alarm_rise, sec_tick;
  assign alarm_rise  = alarm & ~alarm_q;
  assign sec_tick    = prescaler == PW'(CLK_FREQ - 1);
  assign ringing     = state == RING;
  assign snoozed     = state == SNOOZE;
  assign buzzer      = ringing & (prescaler < PW'(CLK_FREQ / 2));
  assign snooze_left = snoozed ? sec_cnt : 12'd0;
  // prescaler restarts on every entry so each ring/snooze second starts with the buzzer on
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      alarm_q   <= 1'b0;
      prescaler <= '0;
      sec_cnt   <= '0;
    end else begin
      alarm_q   <= alarm;
      prescaler <= sec_tick ? '0 : prescaler + 1'b1;
      if (!enable) begin
        state     <= IDLE;
        prescaler <= '0;
      end else begin
        case (state)
          IDLE: begin
            prescaler <= '0;
            if (alarm_rise) begin
              state   <= RING;
              sec_cnt <= '0;
            end
          end
          RING: begin
            if (stop_btn) begin
              state     <= IDLE;
              prescaler <= '0;
            end else if (snooze_btn) begin
              state     <= SNOOZE;
              sec_cnt   <= 12'(SNOOZE_MINS * 60);
              prescaler <= '0;
            end else if (sec_tick && sec_cnt == 12'(RING_SECS - 1)) begin
              state <= IDLE;
            end else if (sec_tick) begin
              sec_cnt <= sec_cnt + 12'd1;
            end
          end
          SNOOZE: begin
            if (stop_btn) begin
              state     <= IDLE;
              prescaler <= '0;
            end else if (alarm_rise || (sec_tick && sec_cnt == 12'd1)) begin
              state     <= RING;
              sec_cnt   <= '0;
              prescaler <= '0;
            end else if (sec_tick) begin
              sec_cnt <= sec_cnt - 12'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
